fpu_shared_arbiter: RTL and testbench

FPU_SHARED_ARBITER -- requirements
Module: fpu_shared_arbiter

---
 rtl/fpu_shared_arbiter_pkg.sv | 32 +++
 rtl/fpu_shared_arbiter_rr.sv | 42 ++++
 rtl/fpu_shared_arbiter.sv | 98 +++++++++
 tb/tb_fpu_shared_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_shared_arbiter_pkg.sv
// Shared FPU definitions: default widths, flag bit positions and the in-flight tag.
package fpu_defs;

  localparam int C_OP   = 32;
  localparam int C_CMD  = 4;
  localparam int C_RM   = 3;
  localparam int FLAG_W = 6;

  // Position of each status bit within the 6-bit flag vector {OF,UF,Zero,IX,IV,Inf}
  localparam int FLAG_OF   = 5;
  localparam int FLAG_UF   = 4;
  localparam int FLAG_ZERO = 3;
  localparam int FLAG_IX   = 2;
  localparam int FLAG_IV   = 1;
  localparam int FLAG_INF  = 0;

  // Wide enough for the largest supported requester count (8)
  localparam int TAG_IDX_W = 3;

  typedef enum logic [C_CMD-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3
  } fpu_op_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
  } tag_t;

endpackage

// File: rtl/fpu_shared_arbiter_rr.sv
// Round-robin arbiter: lowest requesting index at or above the pointer wins;
// the pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_any
);

  logic [IW-1:0] ptr_q;

  // Scan from farthest to nearest so the nearest requester overwrites the result
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int unsigned s;
      s = int'(ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (req[s]) begin
        gnt     = NUM_REQ'(1) << s;
        gnt_idx = IW'(s);
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/fpu_shared_arbiter.sv
// Shares one fixed-latency FPU among NUM_REQ requesters: round-robin issue,
// tag pipeline to route each result back to its requester in grant order.
module fpu_shared_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int C_OP    = fpu_defs::C_OP,
  parameter  int C_CMD   = fpu_defs::C_CMD,
  parameter  int C_RM    = fpu_defs::C_RM,
  parameter  int C_LAT   = 2,
  localparam int IW      = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(C_LAT + 1)
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RBI,
  input  logic [NUM_REQ-1:0]            Req_SI,
  input  logic [NUM_REQ-1:0][C_OP-1:0]  Operand_a_DI,
  input  logic [NUM_REQ-1:0][C_OP-1:0]  Operand_b_DI,
  input  logic [NUM_REQ-1:0][C_RM-1:0]  RM_SI,
  input  logic [NUM_REQ-1:0][C_CMD-1:0] OP_SI,
  output logic [NUM_REQ-1:0]            Gnt_SO,
  output logic [NUM_REQ-1:0]            Rvalid_SO,
  output logic [C_OP-1:0]               Result_DO,
  output logic [fpu_defs::FLAG_W-1:0]   Flags_SO,
  output logic [C_OP-1:0]               Fpu_Operand_a_DO,
  output logic [C_OP-1:0]               Fpu_Operand_b_DO,
  output logic [C_RM-1:0]               Fpu_RM_SO,
  output logic [C_CMD-1:0]              Fpu_OP_SO,
  output logic                          Fpu_Stall_SO,
  output logic                          Fpu_Enable_SO,
  input  logic [C_OP-1:0]               Fpu_Result_DI,
  input  logic [fpu_defs::FLAG_W-1:0]   Fpu_Flags_DI,
  output logic                          Busy_SO
);

  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  fpu_defs::tag_t  tag_q [C_LAT];
  fpu_defs::tag_t  out_tag;
  logic [CNT_W-1:0] cnt_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .req     (Req_SI),
    .gnt     (Gnt_SO),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    Fpu_Operand_a_DO = '0;
    Fpu_Operand_b_DO = '0;
    Fpu_RM_SO        = '0;
    Fpu_OP_SO        = '0;
    if (gnt_any) begin
      Fpu_Operand_a_DO = Operand_a_DI[gnt_idx];
      Fpu_Operand_b_DO = Operand_b_DI[gnt_idx];
      Fpu_RM_SO        = RM_SI[gnt_idx];
      Fpu_OP_SO        = OP_SI[gnt_idx];
    end
  end

  // Tag shifts in lockstep with the FPU pipeline; the last stage aligns with its result
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int s = 0; s < C_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0].valid <= gnt_any;
      tag_q[0].index <= fpu_defs::TAG_IDX_W'(gnt_idx);
      for (int s = 1; s < C_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign out_tag = tag_q[C_LAT-1];

  always_comb begin
    Rvalid_SO = '0;
    for (int i = 0; i < NUM_REQ; i++)
      Rvalid_SO[i] = out_tag.valid && (out_tag.index == fpu_defs::TAG_IDX_W'(i));
  end

  assign Result_DO = out_tag.valid ? Fpu_Result_DI : '0;
  assign Flags_SO  = out_tag.valid ? Fpu_Flags_DI  : '0;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      cnt_q <= '0;
    end else if (gnt_any && !out_tag.valid) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!gnt_any && out_tag.valid) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign Busy_SO       = (cnt_q != '0);
  assign Fpu_Stall_SO  = !gnt_any;
  assign Fpu_Enable_SO = gnt_any || Busy_SO;

endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// Randomized scoreboard bench: issue-side model predicts grants and pushes
// expected responses; an independent monitor pops them when Rvalid appears.
module tb_fpu_shared_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic                Clk_CI = 1'b0;
  logic                Rst_RBI;
  logic [N-1:0]        Req_SI;
  logic [N-1:0][31:0]  Operand_a_DI, Operand_b_DI;
  logic [N-1:0][2:0]   RM_SI;
  logic [N-1:0][3:0]   OP_SI;
  logic [N-1:0]        Gnt_SO, Rvalid_SO;
  logic [31:0]         Result_DO, Fpu_Operand_a_DO, Fpu_Operand_b_DO, Fpu_Result_DI;
  logic [5:0]          Flags_SO, Fpu_Flags_DI;
  logic [2:0]          Fpu_RM_SO;
  logic [3:0]          Fpu_OP_SO;
  logic                Fpu_Stall_SO, Fpu_Enable_SO, Busy_SO;

  fpu_shared_arbiter #(.NUM_REQ(N), .C_OP(32), .C_CMD(4), .C_RM(3), .C_LAT(LAT)) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Req_SI(Req_SI),
    .Operand_a_DI(Operand_a_DI), .Operand_b_DI(Operand_b_DI),
    .RM_SI(RM_SI), .OP_SI(OP_SI), .Gnt_SO(Gnt_SO), .Rvalid_SO(Rvalid_SO),
    .Result_DO(Result_DO), .Flags_SO(Flags_SO),
    .Fpu_Operand_a_DO(Fpu_Operand_a_DO), .Fpu_Operand_b_DO(Fpu_Operand_b_DO),
    .Fpu_RM_SO(Fpu_RM_SO), .Fpu_OP_SO(Fpu_OP_SO),
    .Fpu_Stall_SO(Fpu_Stall_SO), .Fpu_Enable_SO(Fpu_Enable_SO),
    .Fpu_Result_DI(Fpu_Result_DI), .Fpu_Flags_DI(Fpu_Flags_DI), .Busy_SO(Busy_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    int          idx;
    int          due;
    logic [31:0] res;
    logic [5:0]  flg;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ptr = 0;
  int   last_gnt = -100;

  // Stand-in FPU: knows 1.0+2.0 exactly, otherwise an arbitrary but deterministic mix
  function automatic logic [31:0] fpu_res(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [2:0] rm);
    if (op == 4'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b + {25'd0, op, rm};
  endfunction

  function automatic logic [5:0] fpu_flg(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [2:0] rm);
    return a[5:0] ^ b[11:6] ^ {op[2:0], rm};
  endfunction

  logic [31:0] fpu_r [LAT];
  logic [5:0]  fpu_f [LAT];
  always @(posedge Clk_CI) begin
    cyc      <= cyc + 1;
    fpu_r[0] <= fpu_res(Fpu_Operand_a_DO, Fpu_Operand_b_DO, Fpu_OP_SO, Fpu_RM_SO);
    fpu_f[0] <= fpu_flg(Fpu_Operand_a_DO, Fpu_Operand_b_DO, Fpu_OP_SO, Fpu_RM_SO);
    for (int s = 1; s < LAT; s++) begin
      fpu_r[s] <= fpu_r[s-1];
      fpu_f[s] <= fpu_f[s-1];
    end
  end
  assign Fpu_Result_DI = fpu_r[LAT-1];
  assign Fpu_Flags_DI  = fpu_f[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Issue side: predict the grant, check the issue bus, record the expected response
  always @(negedge Clk_CI) begin
    if (!Rst_RBI) begin
      ptr = 0;
      last_gnt = -100;
      q.delete();
      chk("rst_gnt", 64'(Gnt_SO), 64'd0);
      chk("rst_stall", 64'(Fpu_Stall_SO), 64'd1);
      chk("rst_busy", 64'(Busy_SO), 64'd0);
      chk("rst_rvalid_res", {26'd0, Rvalid_SO, Flags_SO, Result_DO}, 64'd0);
    end else begin
      int g;
      bit busy;
      exp_t e;
      g = -1;
      for (int k = N - 1; k >= 0; k--)
        if (Req_SI[(ptr + k) % N]) g = (ptr + k) % N;
      busy = (cyc - last_gnt >= 1) && (cyc - last_gnt <= LAT);
      chk("gnt", 64'(Gnt_SO), (g >= 0) ? 64'(1) << g : 64'd0);
      chk("stall", 64'(Fpu_Stall_SO), 64'(g < 0));
      chk("busy", 64'(Busy_SO), 64'(busy));
      chk("enable", 64'(Fpu_Enable_SO), 64'(g >= 0 || busy));
      if (g >= 0) begin
        chk("issue_ab", {Fpu_Operand_a_DO, Fpu_Operand_b_DO}, {Operand_a_DI[g], Operand_b_DI[g]});
        chk("issue_op_rm", 64'({Fpu_OP_SO, Fpu_RM_SO}), 64'({OP_SI[g], RM_SI[g]}));
        e.idx = g;
        e.due = cyc + LAT;
        e.res = fpu_res(Operand_a_DI[g], Operand_b_DI[g], OP_SI[g], RM_SI[g]);
        e.flg = fpu_flg(Operand_a_DI[g], Operand_b_DI[g], OP_SI[g], RM_SI[g]);
        q.push_back(e);
        ptr = (g + 1) % N;
        last_gnt = cyc;
      end else begin
        chk("issue_idle", {Fpu_Operand_a_DO, Fpu_Operand_b_DO}, 64'd0);
        chk("issue_idle_op_rm", 64'({Fpu_OP_SO, Fpu_RM_SO}), 64'd0);
      end
    end
  end

  // Response monitor
  always @(negedge Clk_CI) begin
    if (Rst_RBI) begin
      if (Rvalid_SO != '0) begin
        if (q.size() == 0) begin
          chk("spurious_rvalid", 64'(Rvalid_SO), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rvalid", 64'(Rvalid_SO), 64'(1) << e.idx);
          chk("rvalid_cycle", 64'(cyc), 64'(e.due));
          chk("result", 64'(Result_DO), 64'(e.res));
          chk("flags", 64'(Flags_SO), 64'(e.flg));
        end
      end else begin
        chk("idle_resp", {26'd0, Flags_SO, Result_DO}, 64'd0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("missing_rvalid_idx", 64'(Rvalid_SO), 64'(1) << q[0].idx);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      Operand_a_DI[i] = $urandom;
      Operand_b_DI[i] = $urandom;
      RM_SI[i]        = 3'($urandom_range(0, 4));
      OP_SI[i]        = 4'($urandom_range(0, 3));
    end
  endtask

  task automatic step(input logic [N-1:0] r);
    Req_SI = r;
    @(posedge Clk_CI);
    #1;
  endtask

  initial begin
    Rst_RBI = 1'b0;
    Req_SI  = '0;
    rand_ops();
    repeat (3) @(posedge Clk_CI);
    #1 Rst_RBI = 1'b1;

    // Single requester 2 with 1.0 + 2.0
    Operand_a_DI[2] = 32'h3F80_0000;
    Operand_b_DI[2] = 32'h4000_0000;
    OP_SI[2]        = 4'd0;
    step(4'b0100);
    // Pointer now 3: wrap to 0, then 2
    rand_ops();
    step(4'b0101);
    step(4'b0101);
    step(4'b0000);
    step(4'b0000);
    // Pointer at 3: requester 1 pulses for one cycle while 3 is served
    step(4'b1010);
    step(4'b1000);
    step(4'b0000);
    step(4'b0000);

    // All four continuously from reset
    Rst_RBI = 1'b0;
    step(4'b0000);
    Rst_RBI = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_ops();
      step(4'b1111);
    end
    step(4'b0000);
    step(4'b0000);
    step(4'b0000);

    // Reset one cycle after a grant discards it
    step(4'b0001);
    Req_SI  = 4'b0000;
    Rst_RBI = 1'b0;
    step(4'b0000);
    step(4'b0000);
    Rst_RBI = 1'b1;
    step(4'b0000);
    step(4'b0000);
    step(4'b0000);

    for (int c = 0; c < 300; c++) begin
      rand_ops();
      step(($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom));
    end
    for (int c = 0; c < LAT + 3; c++) step(4'b0000);

    if (q.size() != 0) chk("drain_pending", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
